// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the instruction/data ROM arbiter.
package rom_arb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 32;

  typedef enum logic [1:0] {ARB_NONE, ARB_IF, ARB_D} arb_sel_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rom_rsp_t;

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Saturating wait counter that bounds how long a pending fetch can be denied.
module rom_arb_starve_cnt #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_o
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = req_i && (cnt_q == CntMax);

endmodule

// File: rtl/rom_arbiter.sv
// Shares one combinational ROM between fetch and data-load ports; data has priority,
// fetch is force-granted after MAX_WAIT denials. ROM_ARB_ERR_EN enables address checking.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i
);

  arb_sel_t    sel, sel_q;
  logic        if_force;
  logic [31:0] win_addr;
  logic        acc_err;
  rom_rsp_t    rsp_d, rsp_q;
  logic [31:0] if_hold_q, d_hold_q;

  rom_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .req_i  (if_req_i),
    .gnt_i  (if_gnt_o),
    .force_o(if_force)
  );

  always_comb begin
    sel = ARB_NONE;
    if (rst) begin
      sel = ARB_NONE;
    end else if (if_force) begin
      sel = ARB_IF;
    end else if (d_req_i) begin
      sel = ARB_D;
    end else if (if_req_i) begin
      sel = ARB_IF;
    end
  end

  assign if_gnt_o = (sel == ARB_IF);
  assign d_gnt_o  = (sel == ARB_D);

  always_comb begin
    win_addr = 32'h0;
    unique case (sel)
      ARB_IF:  win_addr = if_addr_i;
      ARB_D:   win_addr = d_addr_i;
      default: win_addr = 32'h0;
    endcase
  end

`ifdef ROM_ARB_ERR_EN
  localparam logic [29:0] DepthW = 30'(DEPTH);
  assign acc_err    = (sel != ARB_NONE) &&
                      ((win_addr[1:0] != 2'b00) || (win_addr[31:2] >= DepthW));
  assign rom_addr_o = acc_err ? 32'h0 : {win_addr[31:2], 2'b00};
`else
  localparam int unsigned UnusedDepth = DEPTH;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^win_addr[1:0];
  assign acc_err         = 1'b0;
  assign rom_addr_o      = {win_addr[31:2], 2'b00};
`endif

  always_comb begin
    rsp_d.valid = (sel != ARB_NONE);
    rsp_d.err   = acc_err;
    rsp_d.data  = acc_err ? 32'h0 : rom_data_i;
  end

  // Last winner steers the single registered response to its port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= ARB_NONE;
      rsp_q     <= '0;
      if_hold_q <= 32'h0;
      d_hold_q  <= 32'h0;
    end else begin
      sel_q     <= sel;
      rsp_q     <= rsp_d;
      if_hold_q <= if_rdata_o;
      d_hold_q  <= d_rdata_o;
    end
  end

  assign if_rvalid_o = (sel_q == ARB_IF) && rsp_q.valid;
  assign d_rvalid_o  = (sel_q == ARB_D) && rsp_q.valid;
  assign if_err_o    = if_rvalid_o && rsp_q.err;
  assign d_err_o     = d_rvalid_o && rsp_q.err;
  assign if_rdata_o  = if_rvalid_o ? rsp_q.data : if_hold_q;
  assign d_rdata_o   = d_rvalid_o ? rsp_q.data : d_hold_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed-vector bench for rom_arbiter with a behavioural 32-word ROM.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, d_req_i;
  logic [31:0] if_addr_i, d_addr_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] if_rdata_o, d_rdata_o, rom_addr_o, rom_data_i;
  logic [31:0] rom_mem [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data_i = rom_mem[rom_addr_o[6:2]];

  rom_arbiter #(
    .DEPTH   (32),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .if_err_o   (if_err_o),
    .d_req_i    (d_req_i),
    .d_addr_i   (d_addr_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .d_err_o    (d_err_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    rom_mem[0] = 32'h0000_0013;
    rom_mem[1] = 32'h0010_0093;
    rom_mem[2] = 32'h00A0_8093;
    rom_mem[3] = 32'h0020_8113;

    rst = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h8; d_req_i = 1'b1; d_addr_i = 32'h4;
    #2;
    check("rst_if_gnt", 32'(if_gnt_o), 32'h0);
    check("rst_d_gnt", 32'(d_gnt_o), 32'h0);
    check("rst_rom_addr", rom_addr_o, 32'h0);
    step();
    check("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
    check("rst_d_rvalid", 32'(d_rvalid_o), 32'h0);
    check("rst_if_rdata", if_rdata_o, 32'h0);
    check("rst_d_err", 32'(d_err_o), 32'h0);
    if_req_i = 1'b0; d_req_i = 1'b0;
    step();
    rst = 1'b0;

    // Single fetch
    step();
    if_req_i = 1'b1; if_addr_i = 32'h8;
    #1;
    check("s1_if_gnt", 32'(if_gnt_o), 32'h1);
    check("s1_rom_addr", rom_addr_o, 32'h8);
    step();
    if_req_i = 1'b0;
    check("s1_if_rvalid", 32'(if_rvalid_o), 32'h1);
    check("s1_if_rdata", if_rdata_o, 32'h00A0_8093);
    check("s1_d_rvalid", 32'(d_rvalid_o), 32'h0);
    step();
    check("s1_if_rvalid_drop", 32'(if_rvalid_o), 32'h0);
    check("s1_if_rdata_hold", if_rdata_o, 32'h00A0_8093);

    // Simultaneous fetch and load: data wins first
    if_req_i = 1'b1; if_addr_i = 32'h4; d_req_i = 1'b1; d_addr_i = 32'h0;
    #1;
    check("s2_d_gnt", 32'(d_gnt_o), 32'h1);
    check("s2_if_gnt", 32'(if_gnt_o), 32'h0);
    step();
    d_req_i = 1'b0;
    #1;
    check("s2_d_rvalid", 32'(d_rvalid_o), 32'h1);
    check("s2_d_rdata", d_rdata_o, 32'h0000_0013);
    check("s2_if_gnt2", 32'(if_gnt_o), 32'h1);
    step();
    if_req_i = 1'b0;
    check("s2_if_rvalid", 32'(if_rvalid_o), 32'h1);
    check("s2_if_rdata", if_rdata_o, 32'h0010_0093);
    check("s2_d_rvalid_drop", 32'(d_rvalid_o), 32'h0);
    step();

    // Continuous data traffic: fetch force-granted in its 5th waiting cycle
    d_req_i = 1'b1; d_addr_i = 32'h8; if_req_i = 1'b1; if_addr_i = 32'hC;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("s3_if_gnt_c%0d", c), 32'(if_gnt_o), (c == 5) ? 32'h1 : 32'h0);
      check($sformatf("s3_d_gnt_c%0d", c), 32'(d_gnt_o), (c == 5) ? 32'h0 : 32'h1);
      step();
    end
    if_req_i = 1'b0;
    #1;
    check("s3_if_rvalid", 32'(if_rvalid_o), 32'h1);
    check("s3_if_rdata", if_rdata_o, 32'h0020_8113);
    check("s3_d_resume", 32'(d_gnt_o), 32'h1);
    step();
    d_req_i = 1'b0;
    step();

    // Back-to-back loads
    d_req_i = 1'b1; d_addr_i = 32'h0;
    step();
    d_addr_i = 32'h4;
    check("s4_rv0", 32'(d_rvalid_o), 32'h1);
    check("s4_rd0", d_rdata_o, 32'h0000_0013);
    step();
    d_addr_i = 32'h8;
    check("s4_rv1", 32'(d_rvalid_o), 32'h1);
    check("s4_rd1", d_rdata_o, 32'h0010_0093);
    step();
    d_req_i = 1'b0;
    check("s4_rv2", 32'(d_rvalid_o), 32'h1);
    check("s4_rd2", d_rdata_o, 32'h00A0_8093);
    step();
    check("s4_rv_end", 32'(d_rvalid_o), 32'h0);

    // Misaligned / out-of-range loads
    d_req_i = 1'b1; d_addr_i = 32'h6;
    #1;
`ifdef ROM_ARB_ERR_EN
    check("s5_mis_rom_addr", rom_addr_o, 32'h0);
    step();
    d_addr_i = 32'h80;
    check("s5_mis_err", 32'(d_err_o), 32'h1);
    check("s5_mis_rdata", d_rdata_o, 32'h0);
    #1;
    check("s5_oob_rom_addr", rom_addr_o, 32'h0);
    step();
    d_req_i = 1'b0;
    check("s5_oob_rvalid", 32'(d_rvalid_o), 32'h1);
    check("s5_oob_err", 32'(d_err_o), 32'h1);
    check("s5_oob_rdata", d_rdata_o, 32'h0);
`else
    check("s5_mis_rom_addr", rom_addr_o, 32'h4);
    step();
    d_req_i = 1'b0;
    check("s5_mis_rvalid", 32'(d_rvalid_o), 32'h1);
    check("s5_mis_err", 32'(d_err_o), 32'h0);
    check("s5_mis_rdata", d_rdata_o, 32'h0010_0093);
`endif
    step();

    // Reset right after a grant discards the pending response
    if_req_i = 1'b1; if_addr_i = 32'hC;
    #1;
    check("s6_if_gnt", 32'(if_gnt_o), 32'h1);
    if_req_i = 1'b0;
    step();
    if_req_i = 1'b1; if_addr_i = 32'h8;
    rst = 1'b1;
    #1;
    check("s6_rst_rvalid", 32'(if_rvalid_o), 32'h0);
    check("s6_rst_gnt", 32'(if_gnt_o), 32'h0);
    check("s6_rst_rom_addr", rom_addr_o, 32'h0);
    check("s6_rst_if_rdata", if_rdata_o, 32'h0);
    check("s6_rst_d_rdata", d_rdata_o, 32'h0);
    step();
    check("s6_rst_rvalid2", 32'(if_rvalid_o), 32'h0);
    rst = 1'b0;
    #1;
    check("s6_post_gnt", 32'(if_gnt_o), 32'h1);
    step();
    if_req_i = 1'b0;
    check("s6_post_rvalid", 32'(if_rvalid_o), 32'h1);
    check("s6_post_rdata", if_rdata_o, 32'h00A0_8093);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single combinational-read program ROM between the core's instruction-fetch port and its data-load port. Each cycle it grants at most one requester, drives the ROM address, and registers the returned word into a per-requester response. Fixed priority favours data loads; a wait counter bounds fetch starvation. Sits between the fetch/load units and `rom`.

## Interface
- `DEPTH`, 32: ROM size in 32-bit words.
- `MAX_WAIT`, 4: cycles a pending fetch may be denied before it is force-granted; must be ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req_i` in 1: fetch request; held with address until granted.
- `if_addr_i` in 32: fetch byte address.
- `if_gnt_o` out 1: fetch granted this cycle.
- `if_rvalid_o` out 1: fetch response valid, one-cycle pulse.
- `if_rdata_o` out 32: fetch response word.
- `if_err_o` out 1: fetch response error, qualified by `if_rvalid_o`.
- `d_req_i`, `d_addr_i`, `d_gnt_o`, `d_rvalid_o`, `d_rdata_o`, `d_err_o`: identical set for the data port.
- `rom_addr_o` out 32: byte address to ROM.
- `rom_data_i` in 32: ROM read data, combinational from `rom_addr_o`.

## Operation
- Arbitration per cycle: the forced-fetch condition (`wait_cnt == MAX_WAIT` and `if_req_i`) grants fetch; otherwise `d_req_i` wins; otherwise `if_req_i`; otherwise no grant.
- At most one of `if_gnt_o`/`d_gnt_o` is high. Grants are combinational from requests and `wait_cnt`, and are forced low while `rst` is high.
- `rom_addr_o` = winner's address with bits [1:0] cleared; 0 when idle.
- On the edge after a grant, the winner's `rdata` is loaded from `rom_data_i` and its `rvalid` pulses high for exactly one cycle. The other port's `rvalid` is low. A port's `rdata` holds its value between responses.
- `wait_cnt` (width $clog2(MAX_WAIT+1)):
  - increments, saturating at MAX_WAIT, when `if_req_i && !if_gnt_o`;
  - clears when `if_gnt_o` is high or `if_req_i` is low.
- Requester must keep `req` and `addr` stable until `gnt`. Dropping `req` before `gnt` is legal and cancels the request; no response is returned.
- Back-to-back grants are allowed. Throughput is one access per cycle.
- Simultaneous requests with `wait_cnt < MAX_WAIT`: data is granted and fetch waits.
- Reset mid-operation: pending responses are discarded and `wait_cnt` returns to 0.

## Timing
- Grant latency: 0 cycles (same cycle as `req` when it wins).
- Response latency: `rvalid` in cycle N+1 for a grant in cycle N.
- Worst-case fetch latency under continuous data traffic: MAX_WAIT cycles to grant, plus 1 cycle to response.
- Reset values: `if_rvalid_o`, `d_rvalid_o`, `if_err_o`, `d_err_o` = 0; `if_rdata_o`, `d_rdata_o` = 0; `wait_cnt` = 0. `rom_addr_o` and both `gnt` outputs are 0 while `rst` is high.

## Configuration
- `ROM_ARB_ERR_EN` defined:
  - A granted access with `addr[1:0] != 0` or `addr[31:2] >= DEPTH` still completes with `rvalid`.
  - That response has `err` = 1 and `rdata` = 0.
  - `rom_addr_o` is driven as 0 for such an access.
- Undefined:
  - `err` outputs are tied 0.
  - The address is truncated as above and the ROM's data is returned unchanged.

## Structure
- `rom_arb_pkg` holds:
  - `DEPTH_DEFAULT`;
  - `typedef enum logic [1:0] {ARB_NONE, ARB_IF, ARB_D} arb_sel_t`, used for the registered last-winner that steers the response;
  - `typedef struct packed {logic valid; logic err; logic [31:0] data;} rom_rsp_t`.
- One sub-module: `rom_arb_starve_cnt`, the saturating wait counter with a `force` output.
- Arbitration and response registers stay in `rom_arbiter`.

## Test plan
- Single fetch, `if_addr_i`=0x8, ROM[2]=0x00A08093 → `if_gnt_o` same cycle, `if_rvalid_o`=1 and `if_rdata_o`=0x00A08093 next cycle.
- Simultaneous fetch 0x4 and load 0x0 for one cycle → `d_gnt_o` first and `d_rvalid_o` next cycle. Fetch is granted the following cycle and responds one cycle after that.
- `d_req_i` held high continuously with fetch pending, MAX_WAIT=4 → `if_gnt_o` in the 5th cycle of waiting, then data resumes.
- Back-to-back data loads 0x0, 0x4, 0x8 → three consecutive `d_rvalid_o` pulses with ROM[0..2] in order.
- With `ROM_ARB_ERR_EN`, load 0x6 and separately load 0x80 (DEPTH=32) → each responds `d_err_o`=1, `d_rdata_o`=0. Without the macro → `d_err_o`=0 and `d_rdata_o`=ROM[1] for 0x6.
- Assert `rst` the cycle after a grant → no `rvalid` appears and all outputs are 0. After release, a fresh request behaves as in the first scenario.
